uart_byte_transmitter: RTL and testbench

UART_BYTE_TRANSMITTER -- requirements
Module: uart_byte_transmitter

---
 rtl/uart_byte_transmitter.sv | 194 +++++++++++++++++++
 tb/tb_uart_byte_transmitter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_byte_transmitter.sv
// uart_byte_transmitter
//   Serialises up to four bytes of a 32-bit sample word, or one metadata
//   byte, as 8N1 UART frames. With UART_TX_PARITY_EN defined, an even parity
//   bit is added after the data bits (8E1).
//
// Parameters
//   CLOCK_FREQ     system clock frequency in Hz
//   BAUDRATE       serial bit rate; one bit lasts CLOCK_FREQ/BAUDRATE clocks
//
// Ports
//   clock          system clock, rising edge
//   extReset       asynchronous active-high reset
//   dataIn         sample word, byte 0 = bits 7:0
//   disabledGroups bit n set = byte n of dataIn is skipped
//   write          one-cycle request to send dataIn
//   writeMeta      one-cycle request to send meta_data (wins over write)
//   meta_data      metadata byte
//   tx             registered serial output, idle high
//   xmit_idle      high when a new request will be accepted
//
// Configuration macro: UART_TX_PARITY_EN
module uart_byte_transmitter #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUDRATE   = 921600
) (
    input  logic        clock,
    input  logic        extReset,
    input  logic [31:0] dataIn,
    input  logic [3:0]  disabledGroups,
    input  logic        write,
    input  logic        writeMeta,
    input  logic [7:0]  meta_data,
    output logic        tx,
    output logic        xmit_idle
);

    localparam int BAUD_DIV = CLOCK_FREQ / BAUDRATE;
    localparam int BAUD_W   = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [31:0]       data_q;
    logic [3:0]        dis_q;
    logic [7:0]        meta_q;
    logic              meta_sel_q;
    logic [3:0]        sent_q;
    logic [7:0]        byte_q;

    logic [3:0]        pending;
    logic              sel_valid;
    logic [1:0]        sel_idx;
    logic [7:0]        sel_byte;
    logic              baud_end;

    // Bytes still to send: a meta request has exactly one byte (slot 0).
    always_comb begin
        pending   = meta_sel_q ? (~sent_q & 4'b0001) : (~sent_q & ~dis_q);
        sel_valid = |pending;
        sel_idx   = 2'd3;
        if (pending[2]) sel_idx = 2'd2;
        if (pending[1]) sel_idx = 2'd1;
        if (pending[0]) sel_idx = 2'd0;
        case (sel_idx)
            2'd0:    sel_byte = data_q[7:0];
            2'd1:    sel_byte = data_q[15:8];
            2'd2:    sel_byte = data_q[23:16];
            default: sel_byte = data_q[31:24];
        endcase
        if (meta_sel_q) sel_byte = meta_q;
        baud_end = (baud_cnt == BAUD_LAST);
    end

    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            xmit_idle  <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            data_q     <= '0;
            dis_q      <= '0;
            meta_q     <= '0;
            meta_sel_q <= 1'b0;
            sent_q     <= '0;
            byte_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (writeMeta || write) begin
                        data_q     <= dataIn;
                        dis_q      <= disabledGroups;
                        meta_q     <= meta_data;
                        meta_sel_q <= writeMeta;
                        sent_q     <= '0;
                        xmit_idle  <= 1'b0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    baud_cnt <= '0;
                    if (sel_valid) begin
                        byte_q           <= sel_byte;
                        sent_q[sel_idx]  <= 1'b1;
                        tx               <= 1'b0;
                        state            <= START;
                    end else begin
                        xmit_idle <= 1'b1;
                        state     <= IDLE;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= byte_q[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= even_parity(byte_q);
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= byte_q[bit_cnt + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        // Only pass through LOAD when another byte follows;
                        // the last frame ends straight into IDLE.
                        if (|pending) begin
                            state <= LOAD;
                        end else begin
                            xmit_idle <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    tx        <= 1'b1;
                    xmit_idle <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_transmitter.sv
module tb_uart_byte_transmitter;

    localparam int BAUD = 10;
`ifdef UART_TX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int FRAME = BAUD * BITS;

    logic        clock;
    logic        extReset;
    logic [31:0] dataIn;
    logic [3:0]  disabledGroups;
    logic        write;
    logic        writeMeta;
    logic [7:0]  meta_data;
    logic        tx;
    logic        xmit_idle;

    int checks = 0;
    int errors = 0;

    uart_byte_transmitter #(
        .CLOCK_FREQ(1000000),
        .BAUDRATE  (100000)
    ) dut (
        .clock         (clock),
        .extReset      (extReset),
        .dataIn        (dataIn),
        .disabledGroups(disabledGroups),
        .write         (write),
        .writeMeta     (writeMeta),
        .meta_data     (meta_data),
        .tx            (tx),
        .xmit_idle     (xmit_idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        wr;
        logic        meta;
        logic [31:0] data;
        logic [3:0]  dis;
        logic [7:0]  mbyte;
        int          nbytes;
        logic [31:0] exp_bytes;
        int          pulse_k;
        logic        pulse_meta;
    } vec_t;

    vec_t vecs[8];

    logic tx_tr   [512];
    logic idle_tr [512];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected tx after edge k, edge 0 being the accepting edge.
    function automatic logic exp_tx(input int k, input int n, input logic [31:0] bytes);
        int p, f, off, b;
        logic [7:0] by;
        if (k < 1) return 1'b1;
        p   = k - 1;
        f   = p / (FRAME + 1);
        off = p % (FRAME + 1);
        if (f >= n) return 1'b1;
        if (off == FRAME) return 1'b1;
        by = bytes[f*8 +: 8];
        b  = off / BAUD;
        if (b == 0) return 1'b0;
        if (b <= 8) return by[b-1];
        if (BITS == 11 && b == 9) return ^by;
        return 1'b1;
    endfunction

    task automatic run_vec(input vec_t v, input bit skip_sync);
        int idle_len, len, bad, idle_at;
        idle_len = (v.nbytes == 0) ? 1 : v.nbytes * (FRAME + 1);
        len      = idle_len + 20;
        if (!skip_sync) @(negedge clock);
        dataIn         = v.data;
        disabledGroups = v.dis;
        meta_data      = v.mbyte;
        write          = v.wr;
        writeMeta      = v.meta;
        @(posedge clock);
        for (int k = 0; k < len; k++) begin
            @(negedge clock);
            tx_tr[k]   = tx;
            idle_tr[k] = xmit_idle;
            write      = (k == v.pulse_k) && !v.pulse_meta;
            writeMeta  = (k == v.pulse_k) && v.pulse_meta;
            if (k == 5) begin
                dataIn         = ~dataIn;
                disabledGroups = ~disabledGroups;
                meta_data      = ~meta_data;
            end
        end
        bad = -1;
        for (int k = 0; k < len; k++)
            if (bad < 0 && tx_tr[k] !== exp_tx(k, v.nbytes, v.exp_bytes)) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s tx_wave: cycle %0d tx=%b, expected %b",
                     v.name, bad, tx_tr[bad], exp_tx(bad, v.nbytes, v.exp_bytes));
        end
        idle_at = -1;
        for (int k = 0; k < len; k++)
            if (idle_at < 0 && idle_tr[k] === 1'b1) idle_at = k;
        check({v.name, " idle_low_cycles"}, idle_at, idle_len);
        check({v.name, " idle_final"}, int'(idle_tr[len-1]), 1);
    endtask

    initial begin
        vecs[0] = '{"meta_A5",    1'b0, 1'b1, 32'h0,        4'h0,    8'hA5, 1, 32'h000000A5, -1, 1'b0};
        vecs[1] = '{"wr_0101",    1'b1, 1'b0, 32'h44332211, 4'b0101, 8'h00, 2, 32'h00004422, 50, 1'b1};
        vecs[2] = '{"wr_all_off", 1'b1, 1'b0, 32'hCAFEF00D, 4'hF,    8'h00, 0, 32'h0,        -1, 1'b0};
        vecs[3] = '{"wr_and_meta",1'b1, 1'b1, 32'hDEADBEEF, 4'h0,    8'h01, 1, 32'h00000001, 30, 1'b0};
        vecs[4] = '{"wr_4bytes",  1'b1, 1'b0, 32'h8001FF00, 4'h0,    8'h55, 4, 32'h8001FF00, 250, 1'b0};
        vecs[5] = '{"meta_07",    1'b0, 1'b1, 32'h0,        4'h0,    8'h07, 1, 32'h00000007, -1, 1'b0};
        vecs[6] = '{"meta_03",    1'b0, 1'b1, 32'h0,        4'h0,    8'h03, 1, 32'h00000003, -1, 1'b0};
        vecs[7] = '{"wr_byte0",   1'b1, 1'b0, 32'h123456C3, 4'b1110, 8'h00, 1, 32'h000000C3, -1, 1'b0};

        extReset       = 1'b1;
        dataIn         = '0;
        disabledGroups = '0;
        write          = 1'b0;
        writeMeta      = 1'b0;
        meta_data      = '0;
        repeat (3) @(negedge clock);
        check("reset tx", int'(tx), 1);
        check("reset xmit_idle", int'(xmit_idle), 1);
        extReset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b0);

        // Reset in the middle of a frame, then restart on the next edge.
        @(negedge clock);
        meta_data = 8'hA5;
        writeMeta = 1'b1;
        @(posedge clock);
        for (int k = 0; k <= 45; k++) begin
            @(negedge clock);
            writeMeta = 1'b0;
        end
        check("midframe tx before reset", int'(tx), 0);
        check("midframe xmit_idle before reset", int'(xmit_idle), 0);
        extReset = 1'b1;
        #1;
        check("midframe tx at reset", int'(tx), 1);
        check("midframe xmit_idle at reset", int'(xmit_idle), 1);
        @(negedge clock);
        check("midframe tx held in reset", int'(tx), 1);
        extReset = 1'b0;
        run_vec('{"after_reset", 1'b0, 1'b1, 32'h0, 4'h0, 8'h3C, 1, 32'h0000003C, -1, 1'b0}, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
